ls_wb_stage: RTL and testbench

//  Drives the write-back side of the GPR write interface (LS_WB_reg_* / write_data).

---
 rtl/ls_wb_stage_pkg.sv | 27 ++
 rtl/ls_wb_stage_load_data_align.sv | 35 +++
 rtl/ls_wb_stage.sv | 103 ++++++++++
 tb/tb_ls_wb_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_wb_stage_pkg.sv
// Shared encodings for the load/store write-back stage: load sizes,
// bus response codes, FSM states and the latched load context.
package ls_wb_stage_pkg;

    localparam logic [1:0] LS_SIZE_B = 2'd0;
    localparam logic [1:0] LS_SIZE_H = 2'd1;
    localparam logic [1:0] LS_SIZE_W = 2'd2;
    localparam logic [1:0] LS_SIZE_D = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'd0;

    typedef enum logic [1:0] {
        LSWB_IDLE = 2'd0,
        LSWB_AR   = 2'd1,
        LSWB_R    = 2'd2
    } lswb_state_e;

    // Everything about an in-flight load that the write-back needs later
    typedef struct packed {
        logic [4:0] rd;
        logic       dest_wen;
        logic [1:0] size;
        logic       is_unsigned;
        logic [2:0] off;
    } load_ctx_t;

endpackage

// File: rtl/ls_wb_stage_load_data_align.sv
// Combinational load data alignment: picks the addressed bytes out of a
// little-endian doubleword and sign/zero-extends them to XLEN.
// Also usable by a misaligned-load path that supplies its own doubleword.
import ls_wb_stage_pkg::*;

module load_data_align #(
    parameter int XLEN = 64
) (
    input  logic [63:0]     rdata,
    input  logic [2:0]      off,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result
);

    logic [63:0] sh;
    logic [63:0] ext64;

    assign sh = rdata >> {off, 3'b000};

    // Extend the selected field to 64 bits first, then to XLEN
    always_comb begin
        ext64 = sh;
        case (size)
            LS_SIZE_B: ext64 = {{56{sh[7]  & ~is_unsigned}}, sh[7:0]};
            LS_SIZE_H: ext64 = {{48{sh[15] & ~is_unsigned}}, sh[15:0]};
            LS_SIZE_W: ext64 = {{32{sh[31] & ~is_unsigned}}, sh[31:0]};
            default:   ext64 = sh;
        endcase
        // ext64 is already sign-correct for narrow sizes; the signed cast
        // only matters when XLEN is wider than a doubleword.
        result = is_unsigned ? XLEN'(ext64) : XLEN'($signed(ext64));
    end

endmodule

// File: rtl/ls_wb_stage.sv
// Write-back stage of the load/store path. Non-loads (and loads already
// trapped upstream) retire the cycle after acceptance; clean loads run a
// single outstanding data-bus read and retire one cycle after the data beat.
import ls_wb_stage_pkg::*;

module ls_wb_stage #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [4:0]        ex_rd,
    input  logic              ex_dest_wen,
    input  logic              ex_trap_valid,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              ex_load,
    input  logic [1:0]        ex_load_size,
    input  logic              ex_load_unsigned,
    output logic              dbus_arvalid,
    input  logic              dbus_arready,
    output logic [ADDR_W-1:0] dbus_araddr,
    input  logic              dbus_rvalid,
    output logic              dbus_rready,
    input  logic [63:0]       dbus_rdata,
    input  logic [1:0]        dbus_rresp,
    output logic              LS_WB_reg_ls_valid,
    output logic              LS_WB_reg_trap_valid,
    output logic [4:0]        LS_WB_reg_rd,
    output logic              LS_WB_reg_dest_wen,
    output logic [XLEN-1:0]   write_data
);

    lswb_state_e     state;
    load_ctx_t       ctx;
    logic [XLEN-1:0] aligned;

    assign ex_ready     = (state == LSWB_IDLE) && !rst;
    assign dbus_arvalid = (state == LSWB_AR);
    assign dbus_rready  = (state == LSWB_R);

    load_data_align #(.XLEN(XLEN)) u_align (
        .rdata       (dbus_rdata),
        .off         (ctx.off),
        .size        (ctx.size),
        .is_unsigned (ctx.is_unsigned),
        .result      (aligned)
    );

    // FSM, load context and registered write-back outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= LSWB_IDLE;
            ctx                  <= '0;
            dbus_araddr          <= '0;
            LS_WB_reg_ls_valid   <= 1'b0;
            LS_WB_reg_trap_valid <= 1'b0;
            LS_WB_reg_rd         <= '0;
            LS_WB_reg_dest_wen   <= 1'b0;
            write_data           <= '0;
        end else begin
            LS_WB_reg_ls_valid <= 1'b0;
            case (state)
                LSWB_IDLE: begin
                    if (ex_valid) begin
                        if (!ex_load || ex_trap_valid) begin
                            // Pass-through retire; trapped loads never touch the bus
                            LS_WB_reg_ls_valid   <= 1'b1;
                            LS_WB_reg_trap_valid <= ex_trap_valid;
                            LS_WB_reg_rd         <= ex_rd;
                            LS_WB_reg_dest_wen   <= ex_dest_wen;
                            write_data           <= ex_result;
                        end else begin
                            ctx.rd          <= ex_rd;
                            ctx.dest_wen    <= ex_dest_wen;
                            ctx.size        <= ex_load_size;
                            ctx.is_unsigned <= ex_load_unsigned;
                            ctx.off         <= ex_result[2:0];
                            dbus_araddr     <= {ex_result[ADDR_W-1:3], 3'b000};
                            state           <= LSWB_AR;
                        end
                    end
                end
                LSWB_AR: begin
                    if (dbus_arready) state <= LSWB_R;
                end
                LSWB_R: begin
                    if (dbus_rvalid) begin
                        state                <= LSWB_IDLE;
                        LS_WB_reg_ls_valid   <= 1'b1;
                        LS_WB_reg_trap_valid <= (dbus_rresp != RESP_OKAY);
                        LS_WB_reg_rd         <= ctx.rd;
                        LS_WB_reg_dest_wen   <= ctx.dest_wen;
                        write_data           <= (dbus_rresp != RESP_OKAY) ? '0 : aligned;
                    end
                end
                default: state <= LSWB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ls_wb_stage.sv
// Directed bench for ls_wb_stage: a vector table of single ops (ALU and
// loads with bus responses) plus hand sequences for reset, back-to-back
// issue and reset during an outstanding read.
module tb_ls_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic        ex_dest_wen;
    logic        ex_trap_valid;
    logic [63:0] ex_result;
    logic        ex_load;
    logic [1:0]  ex_load_size;
    logic        ex_load_unsigned;
    logic        dbus_arvalid;
    logic        dbus_arready;
    logic [63:0] dbus_araddr;
    logic        dbus_rvalid;
    logic        dbus_rready;
    logic [63:0] dbus_rdata;
    logic [1:0]  dbus_rresp;
    logic        ls_valid;
    logic        trap_valid;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [63:0] write_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ls_wb_stage #(.XLEN(64), .ADDR_W(64)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ex_valid             (ex_valid),
        .ex_ready             (ex_ready),
        .ex_rd                (ex_rd),
        .ex_dest_wen          (ex_dest_wen),
        .ex_trap_valid        (ex_trap_valid),
        .ex_result            (ex_result),
        .ex_load              (ex_load),
        .ex_load_size         (ex_load_size),
        .ex_load_unsigned     (ex_load_unsigned),
        .dbus_arvalid         (dbus_arvalid),
        .dbus_arready         (dbus_arready),
        .dbus_araddr          (dbus_araddr),
        .dbus_rvalid          (dbus_rvalid),
        .dbus_rready          (dbus_rready),
        .dbus_rdata           (dbus_rdata),
        .dbus_rresp           (dbus_rresp),
        .LS_WB_reg_ls_valid   (ls_valid),
        .LS_WB_reg_trap_valid (trap_valid),
        .LS_WB_reg_rd         (wb_rd),
        .LS_WB_reg_dest_wen   (wb_wen),
        .write_data           (write_data)
    );

    typedef struct {
        string       name;
        logic [4:0]  rd;
        logic        wen;
        logic        trap;
        logic        load;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] result;
        int          ar_dly;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        logic [63:0] exp_addr;
        logic [63:0] exp_data;
        logic        exp_trap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [4:0] rd, logic wen, logic trap,
                                logic load, logic [1:0] size, logic uns, logic [63:0] result,
                                int ar_dly, logic [63:0] rdata, logic [1:0] rresp,
                                logic [63:0] exp_addr, logic [63:0] exp_data, logic exp_trap);
        vec_t v;
        v.name = name; v.rd = rd; v.wen = wen; v.trap = trap; v.load = load;
        v.size = size; v.uns = uns; v.result = result; v.ar_dly = ar_dly;
        v.rdata = rdata; v.rresp = rresp; v.exp_addr = exp_addr;
        v.exp_data = exp_data; v.exp_trap = exp_trap;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_rd = 0; ex_dest_wen = 0; ex_trap_valid = 0; ex_result = 0;
        ex_load = 0; ex_load_size = 0; ex_load_unsigned = 0;
        dbus_arready = 0; dbus_rvalid = 0; dbus_rdata = 0; dbus_rresp = 0;
    endtask

    task automatic drive_op(vec_t v);
        ex_valid = 1; ex_rd = v.rd; ex_dest_wen = v.wen; ex_trap_valid = v.trap;
        ex_result = v.result; ex_load = v.load; ex_load_size = v.size;
        ex_load_unsigned = v.uns;
    endtask

    task automatic run_vec(vec_t v);
        chk({v.name, " ex_ready"}, 64'(ex_ready), 64'd1);
        drive_op(v);
        tick();
        ex_valid = 0;
        if (v.load && !v.trap) begin
            chk({v.name, " arvalid"}, 64'(dbus_arvalid), 64'd1);
            chk({v.name, " araddr"}, dbus_araddr, v.exp_addr);
            chk({v.name, " no early retire"}, 64'(ls_valid), 64'd0);
            for (int i = 0; i < v.ar_dly; i++) begin
                tick();
                chk({v.name, " arvalid held"}, 64'(dbus_arvalid), 64'd1);
                chk({v.name, " araddr held"}, dbus_araddr, v.exp_addr);
            end
            dbus_arready = 1;
            tick();
            dbus_arready = 0;
            chk({v.name, " rready"}, 64'(dbus_rready), 64'd1);
            chk({v.name, " arvalid drop"}, 64'(dbus_arvalid), 64'd0);
            dbus_rvalid = 1; dbus_rdata = v.rdata; dbus_rresp = v.rresp;
            tick();
            dbus_rvalid = 0; dbus_rdata = 0; dbus_rresp = 0;
        end else begin
            chk({v.name, " no bus read"}, 64'(dbus_arvalid), 64'd0);
        end
        chk({v.name, " ls_valid"}, 64'(ls_valid), 64'd1);
        chk({v.name, " rd"}, 64'(wb_rd), 64'(v.rd));
        chk({v.name, " wen"}, 64'(wb_wen), 64'(v.wen));
        chk({v.name, " trap"}, 64'(trap_valid), 64'(v.exp_trap));
        chk({v.name, " data"}, write_data, v.exp_data);
        tick();
        chk({v.name, " pulse ends"}, 64'(ls_valid), 64'd0);
    endtask

    logic [4:0]  b2b_rd[4]  = '{5'd1, 5'd2, 5'd3, 5'd4};
    logic [63:0] b2b_res[4] = '{64'hA1, 64'hB2, 64'hC3, 64'hD4};

    initial begin
        vecs.push_back(mk("alu_basic",   5, 1, 0, 0, 0, 0, 64'h1234,             0, 0, 0, 0, 64'h1234, 0));
        vecs.push_back(mk("alu_nowen",  17, 0, 0, 0, 0, 0, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0, 64'hDEAD_BEEF_0000_0001, 0));
        vecs.push_back(mk("alu_trap",    9, 1, 1, 0, 0, 0, 64'h55,               0, 0, 0, 0, 64'h55, 1));
        vecs.push_back(mk("lb_signed",  10, 1, 0, 1, 0, 0, 64'h1003, 2, 64'h0000_0000_8000_0000, 0,
                          64'h1000, 64'hFFFF_FFFF_FFFF_FF80, 0));
        vecs.push_back(mk("lbu",        11, 1, 0, 1, 0, 1, 64'h1003, 2, 64'h0000_0000_8000_0000, 0,
                          64'h1000, 64'h80, 0));
        vecs.push_back(mk("lw_fault",   12, 1, 0, 1, 2, 0, 64'h2004, 0, 64'h8765_4321_0000_0000, 2,
                          64'h2000, 64'h0, 1));
        vecs.push_back(mk("lw_signed",  13, 1, 0, 1, 2, 0, 64'h5004, 1, 64'h8765_4321_1111_2222, 0,
                          64'h5000, 64'hFFFF_FFFF_8765_4321, 0));
        vecs.push_back(mk("lhu_top",    14, 1, 0, 1, 1, 1, 64'h3006, 0, 64'hBEEF_0000_0000_0000, 0,
                          64'h3000, 64'hBEEF, 0));
        vecs.push_back(mk("lh_top",     15, 1, 0, 1, 1, 0, 64'h3006, 0, 64'hBEEF_0000_0000_0000, 0,
                          64'h3000, 64'hFFFF_FFFF_FFFF_BEEF, 0));
        vecs.push_back(mk("ld",         16, 1, 0, 1, 3, 0, 64'h4000, 0, 64'h8000_0000_0000_0001, 0,
                          64'h4000, 64'h8000_0000_0000_0001, 0));
        vecs.push_back(mk("load_trapped", 7, 1, 1, 1, 2, 0, 64'h1001, 0, 0, 0,
                          0, 64'h1001, 1));

        idle_inputs();
        rst = 1;
        tick();
        tick();
        chk("reset ex_ready", 64'(ex_ready), 64'd0);
        chk("reset ls_valid", 64'(ls_valid), 64'd0);
        chk("reset arvalid", 64'(dbus_arvalid), 64'd0);
        chk("reset rready", 64'(dbus_rready), 64'd0);
        chk("reset araddr", dbus_araddr, 64'd0);
        chk("reset data", write_data, 64'd0);
        rst = 0;
        #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back non-load ops: one retire per cycle, in order
        for (int i = 0; i < 4; i++) begin
            chk("b2b ex_ready", 64'(ex_ready), 64'd1);
            ex_valid = 1; ex_rd = b2b_rd[i]; ex_dest_wen = 1; ex_trap_valid = 0;
            ex_load = 0; ex_result = b2b_res[i];
            tick();
            chk("b2b ls_valid", 64'(ls_valid), 64'd1);
            chk("b2b rd", 64'(wb_rd), 64'(b2b_rd[i]));
            chk("b2b data", write_data, b2b_res[i]);
        end
        ex_valid = 0;
        tick();
        chk("b2b tail", 64'(ls_valid), 64'd0);

        // Reset while the read is outstanding drops the load
        ex_valid = 1; ex_rd = 20; ex_dest_wen = 1; ex_trap_valid = 0;
        ex_load = 1; ex_load_size = 3; ex_load_unsigned = 0; ex_result = 64'h6008;
        tick();
        ex_valid = 0;
        dbus_arready = 1;
        tick();
        dbus_arready = 0;
        chk("rst_mid rready", 64'(dbus_rready), 64'd1);
        rst = 1;
        tick();
        chk("rst_mid ex_ready", 64'(ex_ready), 64'd0);
        chk("rst_mid ls_valid", 64'(ls_valid), 64'd0);
        chk("rst_mid rready", 64'(dbus_rready), 64'd0);
        chk("rst_mid araddr", dbus_araddr, 64'd0);
        chk("rst_mid rd", 64'(wb_rd), 64'd0);
        chk("rst_mid data", write_data, 64'd0);
        rst = 0;
        #1;
        chk("rst_mid idle", 64'(ex_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_mid no retire", 64'(ls_valid), 64'd0);
            chk("rst_mid no arvalid", 64'(dbus_arvalid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
